// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN batch controller.
// Imported by the watchdog and the batch controller.
package snn_pkg;

    localparam int DIGIT_W     = 4;
    localparam int NUM_SAMPLES = 10;

    localparam logic [DIGIT_W-1:0] TIMEOUT_DIGIT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RECORD,
        S_GAP,
        S_DONE
    } state_e;

endpackage

// File: rtl/snn_watchdog.sv
// Cycle watchdog: counts while enabled and flags the cycle in which
// the count reaches TIMEOUT_CYCLES-1.
module snn_watchdog
    import snn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && cnt_q != LAST) begin
            cnt_d = cnt_inc;
        end
        // Fires on the cycle whose increment lands on LAST.
        expire = enable && !clear && (cnt_inc == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snn_batch_ctrl.sv
// Batch sequencer: runs snn_core over up to MAX_SAMPLES sample RAMs
// and writes one result (digit or timeout) per sample.
module snn_batch_ctrl
    import snn_pkg::*;
#(
    parameter int MAX_SAMPLES    = NUM_SAMPLES,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int GAP_CYCLES     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               batch_start,
    input  logic [3:0]         num_samples,
    input  logic               abort,
    input  logic               core_done,
    input  logic [DIGIT_W-1:0] core_digit,
    output logic               core_start,
    output logic [3:0]         sample_sel,
    output logic               res_we,
    output logic [3:0]         res_addr,
    output logic [DIGIT_W-1:0] res_digit,
    output logic               res_timeout,
    output logic               busy,
    output logic               batch_done,
    output logic [3:0]         timeout_count
);

    localparam logic [3:0] MAX_N    = 4'(MAX_SAMPLES);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e             state_q, state_d;
    logic [3:0]         n_q, n_d;
    logic [3:0]         sel_q, sel_d;
    logic [3:0]         tcnt_q, tcnt_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               to_q, to_d;
    logic [7:0]         gap_q, gap_d;
    logic               done_prev_q;

    logic       done_edge;
    logic       wd_clear;
    logic       wd_en;
    logic       wd_expire;
    logic [3:0] n_new;

    snn_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk   (clk),
        .rst   (rst),
        .clear (wd_clear),
        .enable(wd_en),
        .expire(wd_expire)
    );

    assign done_edge = core_done & ~done_prev_q;
    assign n_new     = (num_samples > MAX_N) ? MAX_N : num_samples;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        sel_d      = sel_q;
        tcnt_d     = tcnt_q;
        digit_d    = digit_q;
        to_d       = to_q;
        gap_d      = gap_q;
        wd_clear   = 1'b0;
        wd_en      = 1'b0;
        core_start = 1'b0;
        res_we     = 1'b0;
        batch_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (batch_start) begin
                    n_d     = n_new;
                    sel_d   = '0;
                    tcnt_d  = '0;
                    state_d = (n_new == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                wd_clear   = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                // A real result beats a simultaneous watchdog expiry.
                if (done_edge) begin
                    digit_d = core_digit;
                    to_d    = 1'b0;
                    state_d = S_RECORD;
                end else if (wd_expire) begin
                    digit_d = TIMEOUT_DIGIT;
                    to_d    = 1'b1;
                    tcnt_d  = (tcnt_q == 4'hF) ? tcnt_q : tcnt_q + 4'd1;
                    state_d = S_RECORD;
                end
            end
            S_RECORD: begin
                res_we = 1'b1;
                if (sel_q == n_q - 4'd1) begin
                    state_d = S_DONE;
                end else if (GAP_CYCLES == 0) begin
                    sel_d   = sel_q + 4'd1;
                    state_d = S_LAUNCH;
                end else begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    sel_d   = sel_q + 4'd1;
                    state_d = S_LAUNCH;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_DONE: begin
                batch_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            tcnt_d     = tcnt_q;
            core_start = 1'b0;
            res_we     = 1'b0;
            batch_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            sel_q       <= '0;
            tcnt_q      <= '0;
            digit_q     <= '0;
            to_q        <= 1'b0;
            gap_q       <= '0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            sel_q       <= sel_d;
            tcnt_q      <= tcnt_d;
            digit_q     <= digit_d;
            to_q        <= to_d;
            gap_q       <= gap_d;
            done_prev_q <= core_done;
        end
    end

    assign sample_sel    = sel_q;
    assign timeout_count = tcnt_q;
    assign busy          = (state_q != S_IDLE);
    assign res_addr      = res_we ? sel_q : '0;
    assign res_digit     = res_we ? digit_q : '0;
    assign res_timeout   = res_we & to_q;

endmodule

// File: tb/tb_snn_batch_ctrl.sv
// Bench for snn_batch_ctrl: behavioural core with per-sample label RAMs,
// result scoreboard and directed batch scenarios.
module tb_snn_batch_ctrl;

    localparam int T  = 100;
    localparam int G  = 2;
    localparam int MS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       batch_start;
    logic [3:0] num_samples;
    logic       abort;
    logic       core_done;
    logic [3:0] core_digit;
    logic       core_start;
    logic [3:0] sample_sel;
    logic       res_we;
    logic [3:0] res_addr;
    logic [3:0] res_digit;
    logic       res_timeout;
    logic       busy;
    logic       batch_done;
    logic [3:0] timeout_count;

    snn_batch_ctrl #(
        .MAX_SAMPLES   (MS),
        .TIMEOUT_CYCLES(T),
        .GAP_CYCLES    (G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .batch_start  (batch_start),
        .num_samples  (num_samples),
        .abort        (abort),
        .core_done    (core_done),
        .core_digit   (core_digit),
        .core_start   (core_start),
        .sample_sel   (sample_sel),
        .res_we       (res_we),
        .res_addr     (res_addr),
        .res_digit    (res_digit),
        .res_timeout  (res_timeout),
        .busy         (busy),
        .batch_done   (batch_done),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample RAMs: each holds its label; sample_sel muxes the core input.
    logic [3:0] labels [MS];
    logic [3:0] res_mem [16];
    int  lat;
    bit  stub;
    int  ccnt;

    always @(posedge clk or posedge rst) begin
        if (rst) ccnt <= 0;
        else if (core_start) ccnt <= 1;
        else if (ccnt != 0 && ccnt < 100000) ccnt <= ccnt + 1;
    end

    assign core_done  = !stub && ccnt != 0 && ccnt >= lat;
    assign core_digit = core_done ? labels[sample_sel] : 4'h0;

    typedef struct {
        int addr;
        int digit;
        int to;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   cyc = 0;
    int   we_cnt = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (core_start) starts.push_back(cyc);
        if (batch_done) done_cnt++;
        if (res_we) begin
            we_cnt++;
            res_mem[res_addr] = res_digit;
            if (exp_q.size() == 0) begin
                chk("spurious_we", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("res_addr", res_addr, e.addr);
                chk("res_digit", res_digit, e.digit);
                chk("res_timeout", res_timeout, e.to);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_batch(input int n, input bit to_mode);
        int m;
        m = (n > MS) ? MS : n;
        for (int i = 0; i < m; i++) begin
            exp_q.push_back('{i, to_mode ? 15 : int'(labels[i]), int'(to_mode)});
        end
    endtask

    task automatic start(input logic [3:0] n);
        batch_start = 1'b1;
        num_samples = n;
        tick();
        batch_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", busy, 0);
    endtask

    int we0;
    int done0;
    int k;

    initial begin
        rst         = 1'b1;
        batch_start = 1'b0;
        num_samples = '0;
        abort       = 1'b0;
        stub        = 1'b0;
        lat         = 5;
        for (int i = 0; i < MS; i++) labels[i] = 4'((i * 7 + 3) % 10);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sample_sel, 0);
        chk("rst_we", res_we, 0);
        chk("rst_tcnt", timeout_count, 0);
        chk("rst_start", core_start, 0);
        chk("rst_bdone", batch_done, 0);
        rst = 1'b0;
        tick();

        // Full batch of ten.
        we0 = we_cnt; done0 = done_cnt;
        push_batch(10, 1'b0);
        start(4'd10);
        wait_idle(5000);
        chk("full_writes", we_cnt - we0, 10);
        chk("full_bdone", done_cnt - done0, 1);
        chk("full_tcnt", timeout_count, 0);
        chk("full_q_empty", exp_q.size(), 0);
        chk("full_mem9", res_mem[9], labels[9]);

        // Every sample times out.
        tick();
        stub = 1'b1;
        we0 = we_cnt;
        starts.delete();
        push_batch(2, 1'b1);
        start(4'd2);
        wait_idle(1000);
        chk("to_writes", we_cnt - we0, 2);
        chk("to_tcnt", timeout_count, 2);
        chk("to_starts", starts.size(), 2);
        if (starts.size() == 2) chk("to_spacing", starts[1] - starts[0], T + 1 + G);
        stub = 1'b0;

        // Clamp to MAX_SAMPLES.
        tick();
        lat = 3;
        we0 = we_cnt; done0 = done_cnt;
        push_batch(13, 1'b0);
        start(4'd13);
        wait_idle(5000);
        chk("clamp_writes", we_cnt - we0, 10);
        chk("clamp_bdone", done_cnt - done0, 1);
        chk("clamp_tcnt", timeout_count, 0);

        // Zero-length batch.
        tick();
        we0 = we_cnt;
        start(4'd0);
        chk("zero_bdone", batch_done, 1);
        chk("zero_busy_done", busy, 1);
        tick();
        chk("zero_busy", busy, 0);
        chk("zero_writes", we_cnt - we0, 0);

        // Abort while waiting on sample 3.
        tick();
        lat = 20;
        we0 = we_cnt; done0 = done_cnt;
        push_batch(3, 1'b0);
        start(4'd10);
        k = 0;
        while (!(core_start && sample_sel == 4'd3) && k < 2000) begin
            tick();
            k++;
        end
        chk("abort_reach", int'(k < 2000), 1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (40) tick();
        chk("abort_writes", we_cnt - we0, 3);
        chk("abort_bdone", done_cnt - done0, 0);
        chk("abort_q_empty", exp_q.size(), 0);

        // Reset during the gap after sample 1.
        lat = 5;
        push_batch(2, 1'b0);
        start(4'd4);
        k = 0;
        while (!(res_we && sample_sel == 4'd1) && k < 2000) begin
            tick();
            k++;
        end
        chk("rstgap_reach", int'(k < 2000), 1);
        tick();
        chk("rstgap_sel_pre", sample_sel, 1);
        rst = 1'b1;
        #1;
        chk("rstgap_busy", busy, 0);
        chk("rstgap_sel", sample_sel, 0);
        chk("rstgap_we", res_we, 0);
        chk("rstgap_addr", res_addr, 0);
        chk("rstgap_start", core_start, 0);
        chk("rstgap_tcnt", timeout_count, 0);
        tick();
        rst = 1'b0;
        chk("rstgap_q_empty", exp_q.size(), 0);
        tick();
        we0 = we_cnt; done0 = done_cnt;
        push_batch(2, 1'b0);
        start(4'd2);
        wait_idle(2000);
        chk("post_rst_writes", we_cnt - we0, 2);
        chk("post_rst_bdone", done_cnt - done0, 1);

        // Done edge on the expiry cycle, plus start while busy.
        tick();
        lat = T - 1;
        we0 = we_cnt; done0 = done_cnt;
        push_batch(1, 1'b0);
        start(4'd1);
        repeat (10) tick();
        start(4'd5);
        wait_idle(1000);
        chk("coll_writes", we_cnt - we0, 1);
        chk("coll_bdone", done_cnt - done0, 1);
        chk("coll_tcnt", timeout_count, 0);

        // One cycle later the watchdog wins.
        tick();
        lat = T;
        exp_q.push_back('{0, 15, 1});
        start(4'd1);
        wait_idle(1000);
        chk("late_tcnt", timeout_count, 1);
        chk("late_q_empty", exp_q.size(), 0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
